my_mac_acc_lanes: RTL and testbench

Parametrised multi-lane signed fixed-point multiply-accumulate engine with a full valid/ready handshake. It is the successor to the single-lane floating-point MAC wrapper in the neural-datapath library. It accumulates per-lane dot products over vectors framed by `first`/`last` markers, and emits one result beat per vector. It sits between the operand streamers and the activation/quantisation stage, and supports back-pressure, optional saturation, sticky overflow flags and a term counter.

---
 rtl/my_mac_pkg.sv | 34 +++
 rtl/my_mac_lane.sv | 89 ++++++++
 rtl/my_mac_acc_lanes.sv | 113 +++++++++++
 tb/tb_my_mac_acc_lanes.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/my_mac_pkg.sv
// Shared constants and arithmetic helpers for the multi-lane MAC engine.
// sat_add works on sign-extended wide operands so one body serves any accumulator width.
package my_mac_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LANES  = 4;
  localparam int DEF_PIPE   = 2;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_W      = 128;

  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Operands must already be sign-extended w-bit values, so the wide sum never wraps
  // and a range test is equivalent to the classic sign-based overflow rule.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                    input logic sat, output logic ovf);
    wide_t hi;
    wide_t lo;
    wide_t s;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = ~hi;
    s   = a + b;
    ovf = (s > hi) || (s < lo);
    if (ovf && sat)
      s = (s > hi) ? hi : lo;
    return s;
  endfunction

endpackage

// File: rtl/my_mac_lane.sv
// One MAC lane: product pipeline, accumulator with optional saturation and sticky
// overflow, and the result register loaded by the shared load_out strobe.
module my_mac_lane
  import my_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PIPE   = DEF_PIPE,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     tap_valid,
  input  logic                     tap_first,
  input  logic                     load_out,
  output logic signed [ACC_W-1:0]  result,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] mult;
  logic signed [ACC_W-1:0]    prod_q [PIPE];
  logic signed [ACC_W-1:0]    prod_d [PIPE];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    result_q, result_d;
  logic signed [ACC_W-1:0]    sum_val;
  logic                       sum_ovf;
  logic                       ovf_acc_q, ovf_acc_d;
  logic                       ovf_q, ovf_d;

  assign mult = a * b;

  always_comb begin
    for (int i = 0; i < PIPE; i++)
      prod_d[i] = prod_q[i];
    if (en) begin
      prod_d[0] = ACC_W'(mult);
      for (int i = 1; i < PIPE; i++)
        prod_d[i] = prod_q[i-1];
    end
  end

  // The output register takes the accumulator one cycle after its final update.
  always_comb begin
    sum_val   = ACC_W'(sat_add(wide_t'(acc_q), wide_t'(prod_q[PIPE-1]), ACC_W,
                               SAT != 0, sum_ovf));
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    if (en && tap_valid) begin
      if (tap_first) begin
        acc_d     = prod_q[PIPE-1];
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = sum_val;
        ovf_acc_d = ovf_acc_q | sum_ovf;
      end
    end
    result_d = result_q;
    ovf_d    = ovf_q;
    if (load_out) begin
      result_d = acc_q;
      ovf_d    = ovf_acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < PIPE; i++)
        prod_q[i] <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < PIPE; i++)
        prod_q[i] <= prod_d[i];
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/my_mac_acc_lanes.sv
// Multi-lane signed MAC with valid/ready handshake; one result beat per first..last vector.
// Holds the sideband pipe, term counter and output flag; lanes do the arithmetic.
module my_mac_acc_lanes
  import my_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LANES  = DEF_LANES,
  parameter int PIPE   = DEF_PIPE,
  parameter int SAT    = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ivalid,
  output logic                    oready,
  input  logic                    first,
  input  logic                    last,
  input  logic [LANES*DATA_W-1:0] datainA,
  input  logic [LANES*DATA_W-1:0] datainB,
  output logic                    ovalid,
  input  logic                    iready,
  output logic [LANES*ACC_W-1:0]  dataout,
  output logic [LANES-1:0]        ovf,
  output logic [CNT_W-1:0]        count
);

  logic [PIPE-1:0]  vld_q, vld_d;
  logic [PIPE-1:0]  first_q, first_d;
  logic [PIPE-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_q, load_d;
  logic             ovalid_q, ovalid_d;
  logic             en;
  logic             load_out;

  // A pending result that downstream refuses freezes the entire pipe.
  assign oready = !(ovalid_q && !iready);
  assign en     = oready;

  always_comb begin
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    if (en) begin
      vld_d[0]   = ivalid;
      first_d[0] = first;
      last_d[0]  = last;
      for (int i = 1; i < PIPE; i++) begin
        vld_d[i]   = vld_q[i-1];
        first_d[i] = first_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end

    cnt_d = cnt_q;
    if (en && vld_q[PIPE-1])
      cnt_d = first_q[PIPE-1] ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    load_d = load_q;
    if (en)
      load_d = vld_q[PIPE-1] && last_q[PIPE-1];

    load_out = en && load_q;
    count_d  = load_out ? cnt_q : count_q;
    ovalid_d = load_out ? 1'b1 : (iready ? 1'b0 : ovalid_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      load_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      first_q  <= first_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      load_q   <= load_d;
      ovalid_q <= ovalid_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    my_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .PIPE   (PIPE),
      .SAT    (SAT)
    ) u_lane (
      .clk       (clock),
      .srst      (reset),
      .en        (en),
      .a         (datainA[lane_lsb(gi, DATA_W) +: DATA_W]),
      .b         (datainB[lane_lsb(gi, DATA_W) +: DATA_W]),
      .tap_valid (vld_q[PIPE-1]),
      .tap_first (first_q[PIPE-1]),
      .load_out  (load_out),
      .result    (dataout[lane_lsb(gi, ACC_W) +: ACC_W]),
      .ovf       (ovf[gi])
    );
  end

  assign ovalid = ovalid_q;
  assign count  = count_q;

endmodule

// File: tb/tb_my_mac_acc_lanes.sv
// Scoreboard bench: two instances (saturating and wrapping) share stimulus; expected
// results are queued at issue time and popped by a monitor on each accepted output beat.
module tb_my_mac_acc_lanes;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int P  = 2;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset, ivalid, first, last, iready;
  logic [L*DW-1:0] datainA, datainB;
  logic            oready_s, ovalid_s, oready_w, ovalid_w;
  logic [L*AW-1:0] dataout_s, dataout_w;
  logic [L-1:0]    ovf_s, ovf_w;
  logic [CW-1:0]   count_s, count_w;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [L*AW-1:0] ds;
    logic [L*AW-1:0] dw;
    logic [L-1:0]    os;
    logic [L-1:0]    ow;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   t, t2;

  int ta [8] = '{3, -5, 7, 100, -128, 0, 32767, -32768};
  int tb [8] = '{4, 6, -8, 100, -128, 9, 32767, -32768};
  int te [8] = '{12, -30, -56, 10000, 16384, 0, 1073676289, 1073741824};

  my_mac_acc_lanes #(.DATA_W(DW), .ACC_W(AW), .LANES(L), .PIPE(P), .SAT(1), .CNT_W(CW)) dut_sat (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready_s), .first(first), .last(last),
    .datainA(datainA), .datainB(datainB), .ovalid(ovalid_s), .iready(iready),
    .dataout(dataout_s), .ovf(ovf_s), .count(count_s));

  my_mac_acc_lanes #(.DATA_W(DW), .ACC_W(AW), .LANES(L), .PIPE(P), .SAT(0), .CNT_W(CW)) dut_wrap (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready_w), .first(first), .last(last),
    .datainA(datainA), .datainB(datainB), .ovalid(ovalid_w), .iready(iready),
    .dataout(dataout_w), .ovf(ovf_w), .count(count_w));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  function automatic logic [127:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push(input logic [127:0] ds, input logic [127:0] dw,
                      input logic [3:0] os, input logic [3:0] ow, input int cnt);
    exp_t e;
    e.ds = ds; e.dw = dw; e.os = os; e.ow = ow; e.cnt = CW'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic f, input logic l, input int a0, input int b0,
                      input int a1, input int b1, input int a2, input int b2,
                      input int a3, input int b3, output int tries);
    logic ok;
    ivalid  = 1'b1;
    first   = f;
    last    = l;
    datainA = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    datainB = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    tries   = 0;
    ok      = 1'b0;
    while (!ok && tries < 200) begin
      tries++;
      @(negedge clock);
      ok = oready_s;
      @(posedge clock);
      #1;
    end
    if (!ok) chk("accept_timeout", 128'(ok), 128'(1));
    ivalid = 1'b0;
    first  = 1'b0;
    last   = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++)
      @(negedge clock);
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clock);
    #1;
  endtask

  // A result is consumed on the edge following a negedge that sees ovalid && iready.
  always @(negedge clock) begin
    if (!reset && ovalid_s && iready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 128'(ovalid_s), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        $display("result: sat=%h wrap=%h ovf=%b/%b count=%0d", dataout_s, dataout_w, ovf_s, ovf_w, count_s);
        chk("data_sat",    dataout_s,      mon_e.ds);
        chk("ovf_sat",     128'(ovf_s),    128'(mon_e.os));
        chk("count_sat",   128'(count_s),  128'(mon_e.cnt));
        chk("ovalid_wrap", 128'(ovalid_w), 128'(1));
        chk("data_wrap",   dataout_w,      mon_e.dw);
        chk("ovf_wrap",    128'(ovf_w),    128'(mon_e.ow));
        chk("count_wrap",  128'(count_w),  128'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ivalid = 1'b0; first = 1'b0; last = 1'b0; iready = 1'b1;
    datainA = '0; datainB = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ovalid",  128'(ovalid_s),  128'(0));
    chk("rst_oready",  128'(oready_s),  128'(1));
    chk("rst_dataout", dataout_s,       128'(0));
    chk("rst_ovf",     128'(ovf_s),     128'(0));
    chk("rst_count",   128'(count_s),   128'(0));

    // Three-beat vector, then exact output latency.
    push(pk(-7, 14, -600, 0), pk(-7, 14, -600, 0), 4'b0, 4'b0, 3);
    beat(1, 0,  2, 3, 1, 1, -1, 100, 0, 5, t);
    beat(0, 0, -4, 5, 2, 2, -2, 100, 0, 5, t);
    beat(0, 1,  7, 1, 3, 3, -3, 100, 0, 5, t);
    for (int k = 0; k < P + 2; k++) begin
      @(negedge clock);
      chk("latency_ovalid", 128'(ovalid_s), 128'(k == P + 1));
    end

    // Back-to-back single-beat vectors.
    drain();
    for (int i = 0; i < 8; i++) begin
      push(pk(te[i], ta[i], tb[i], -ta[i]), pk(te[i], ta[i], tb[i], -ta[i]), 4'b0, 4'b0, 1);
      beat(1, 1, ta[i], tb[i], ta[i], 1, 1, tb[i], ta[i], -1, t);
      chk("single_no_stall", 128'(t), 128'(1));
    end

    // Back-pressure with a vector in flight and a beat offered during the stall.
    drain();
    iready = 1'b0;
    push(pk(100, 0, 0, 0), pk(100, 0, 0, 0), 4'b0, 4'b0, 1);
    beat(1, 1, 10, 10, 0, 0, 0, 0, 0, 0, t);
    push(pk(25, -7, 0, 6), pk(25, -7, 0, 6), 4'b0, 4'b0, 2);
    beat(1, 0, 3, 3, 1, -3, 0, 9, 2, 1, t);
    beat(0, 1, 4, 4, 2, -2, 0, 9, 2, 2, t);
    for (int k = 0; k < 10 && !ovalid_s; k++) @(negedge clock);
    chk("stall_ovalid", 128'(ovalid_s), 128'(1));
    push(pk(-25, 0, 0, 0), pk(-25, 0, 0, 0), 4'b0, 4'b0, 1);
    fork
      beat(1, 1, 5, -5, 0, 0, 0, 0, 0, 0, t2);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          chk("stall_oready", 128'(oready_s), 128'(0));
          chk("stall_hold",   dataout_s,      pk(100, 0, 0, 0));
          chk("stall_count",  128'(count_s),  128'(1));
        end
        @(posedge clock);
        #1 iready = 1'b1;
      end
    join

    // Saturating versus wrapping accumulation.
    drain();
    push(pk(32'h7FFFFFFF, 3, 32'h80000000, 0), pk(32'hC0000000, 3, 1073840128, 0), 4'b0101, 4'b0101, 3);
    for (int k = 0; k < 3; k++)
      beat(k == 0, k == 2, -32768, -32768, 1, 1, -32768, 32767, 0, 0, t);

    // Bubbles between beats.
    drain();
    push(pk(100, -40, 0, 40000), pk(100, -40, 0, 40000), 4'b0, 4'b0, 4);
    for (int k = 0; k < 4; k++) begin
      beat(k == 0, k == 3, 2 * k + 1, 2 * k + 2, 10, -1, 0, 0, 100, 100, t);
      if (k < 3) begin
        repeat (2) @(posedge clock);
        #1;
      end
    end

    // Reset in the middle of a vector.
    drain();
    beat(1, 0, 9, 9, 9, 9, 9, 9, 9, 9, t);
    beat(0, 0, 9, 9, 9, 9, 9, 9, 9, 9, t);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_ovalid",  128'(ovalid_s), 128'(0));
    chk("midrst_oready",  128'(oready_s), 128'(1));
    chk("midrst_dataout", dataout_s,      128'(0));
    chk("midrst_ovf",     128'(ovf_s),    128'(0));
    chk("midrst_count",   128'(count_s),  128'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("midrst_no_result", 128'(ovalid_s), 128'(0));
    end
    @(posedge clock);
    #1;
    push(pk(4, 0, 0, 0), pk(4, 0, 0, 0), 4'b0, 4'b0, 1);
    beat(0, 1, 2, 2, 0, 0, 0, 0, 0, 0, t);
    push(pk(19, 0, 0, 0), pk(19, 0, 0, 0), 4'b0, 4'b0, 2);
    beat(1, 0, 5, 5, 0, 0, 0, 0, 0, 0, t);
    beat(0, 1, 6, -1, 0, 0, 0, 0, 0, 0, t);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
